// File: rtl/decode_stage_p.sv
// -----------------------------------------------------------------------------
// decode_stage_p
//
// Decode stage of a 5-stage MIPS pipeline. Holds the IF/ID pipeline register
// with a valid bit, the architectural register file with same-cycle
// write-through bypass, the control decoder, early branch resolution with
// 3-way operand forwarding and the branch/jump target adders.
//
// Optional feature macro: DEC_STAT_EN
//   When defined, adds saturating stall/flush performance counters and the
//   StallCnt/FlushCnt ports. When undefined, those ports do not exist.
//
// Ports:
//   CLK                 clock, all state updates on the rising edge
//   rst                 synchronous active-low reset
//   RD                  instruction word from instruction memory
//   PCPlus4F            fetch PC+4
//   StallD              hold the IF/ID register
//   ForwardAD/BD        branch operand select: 01 ALUOutM, 10 ResultW,
//                       00/11 register file
//   ALUOutM, ResultW    forwarded values
//   RegWriteW/WriteRegW writeback enable / address
//   RD1, RD2            register file read data (bypass included)
//   SignImmD            extended immediate
//   PCBranchD, PCjump   branch and jump targets
//   PCSrcD              {jump taken, branch taken}
//   RsD, RtD, RdD       register specifiers from the decoded instruction
//   ALUControlD ..      decoded control signals (all 0 / ALU add on a bubble)
//   ValidD              the IF/ID register holds a real instruction
//   StallCnt, FlushCnt  performance counters (DEC_STAT_EN only)
//
// Flow control: ValidD qualifies every control output. There is no
// backpressure handshake here; StallD from the hazard unit freezes the stage
// and a taken branch/jump squashes the instruction being fetched behind it.
// -----------------------------------------------------------------------------
module decode_stage_p #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [31:0]     RD,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            StallD,
  input  logic [1:0]      ForwardAD,
  input  logic [1:0]      ForwardBD,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic [XLEN-1:0] ResultW,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   WriteRegW,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] SignImmD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [XLEN-1:0] PCjump,
  output logic [1:0]      PCSrcD,
  output logic [AW-1:0]   RsD,
  output logic [AW-1:0]   RtD,
  output logic [AW-1:0]   RdD,
  output logic [2:0]      ALUControlD,
  output logic            MemWriteD,
  output logic            RegWriteD,
  output logic            RegDstD,
  output logic            ALUSrcD,
  output logic            MemtoRegD,
  output logic            JumpD,
  output logic            BranchD,
  output logic            ValidD
`ifdef DEC_STAT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  if (XLEN < 32 || AW != $clog2(NREG) || NREG > 32 || CNT_W < 1) begin : g_param_check
    $error("decode_stage_p: illegal parameter combination");
  end

  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCPlus4D;
  logic [XLEN-1:0] regFile [NREG];
  logic [5:0]      opD;
  logic [5:0]      functD;
  logic [15:0]     immD;
  logic            FlushD;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            branchCond;

  assign opD    = InstrD[31:26];
  assign functD = InstrD[5:0];
  assign immD   = InstrD[15:0];
  assign RsD    = InstrD[21 +: AW];
  assign RtD    = InstrD[16 +: AW];
  assign RdD    = InstrD[11 +: AW];

  // A redirect squashes the instruction being fetched, unless the stage is
  // frozen (PCSrcD is already forced to 00 in that case).
  assign FlushD = (PCSrcD != 2'b00) & ~StallD;

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rst) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (FlushD) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= RD;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. Entry 0 is never written and is masked on read anyway.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
    end else if (RegWriteW && (WriteRegW != '0)) begin
      regFile[WriteRegW] <= ResultW;
    end
  end

  // Write-through bypass so writeback and decode can share a cycle.
  always_comb begin
    RD1 = regFile[RsD];
    if (RsD == '0)                             RD1 = '0;
    else if (RegWriteW && (WriteRegW == RsD))  RD1 = ResultW;
  end

  always_comb begin
    RD2 = regFile[RtD];
    if (RtD == '0)                             RD2 = '0;
    else if (RegWriteW && (WriteRegW == RtD))  RD2 = ResultW;
  end

  // ---------------------------------------------------------------------------
  // Control decode. Unknown encodings and bubbles collapse to a NOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic known;
    known       = 1'b1;
    ALUControlD = ALU_ADD;
    MemWriteD   = 1'b0;
    RegWriteD   = 1'b0;
    RegDstD     = 1'b0;
    ALUSrcD     = 1'b0;
    MemtoRegD   = 1'b0;
    JumpD       = 1'b0;
    BranchD     = 1'b0;
    case (opD)
      OP_RTYPE: begin
        RegWriteD = 1'b1;
        RegDstD   = 1'b1;
        case (functD)
          FN_ADD:  ALUControlD = ALU_ADD;
          FN_SUB:  ALUControlD = ALU_SUB;
          FN_AND:  ALUControlD = ALU_AND;
          FN_OR:   ALUControlD = ALU_OR;
          FN_SLT:  ALUControlD = ALU_SLT;
          default: known = 1'b0;
        endcase
      end
      OP_LW: begin
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        MemtoRegD = 1'b1;
      end
      OP_SW: begin
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
      end
      OP_ADDI: begin
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
      end
      OP_ANDI: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = ALU_AND;
      end
      OP_ORI: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = ALU_OR;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        BranchD     = 1'b1;
        ALUControlD = ALU_SUB;
      end
      OP_J:    JumpD = 1'b1;
      default: known = 1'b0;
    endcase
    if (!ValidD || !known) begin
      ALUControlD = ALU_ADD;
      MemWriteD   = 1'b0;
      RegWriteD   = 1'b0;
      RegDstD     = 1'b0;
      ALUSrcD     = 1'b0;
      MemtoRegD   = 1'b0;
      JumpD       = 1'b0;
      BranchD     = 1'b0;
    end
  end

  // Logical immediates are zero-extended, everything else sign-extended.
  always_comb begin
    if (opD == OP_ANDI || opD == OP_ORI) SignImmD = {{(XLEN-16){1'b0}}, immD};
    else                                 SignImmD = {{(XLEN-16){immD[15]}}, immD};
  end

  // ---------------------------------------------------------------------------
  // Early branch resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ForwardAD)
      2'b01:   srcA = ALUOutM;
      2'b10:   srcA = ResultW;
      default: srcA = RD1;
    endcase
    case (ForwardBD)
      2'b01:   srcB = ALUOutM;
      2'b10:   srcB = ResultW;
      default: srcB = RD2;
    endcase
  end

  always_comb begin
    case (opD)
      OP_BEQ:  branchCond = (srcA == srcB);
      OP_BNE:  branchCond = (srcA != srcB);
      OP_BLEZ: branchCond = srcA[XLEN-1] | (srcA == '0);
      OP_BGTZ: branchCond = ~srcA[XLEN-1] & (srcA != '0);
      default: branchCond = 1'b0;
    endcase
  end

  // Forwarded operands may be stale while stalled, so no redirect then.
  assign PCSrcD[0] = BranchD & branchCond & ValidD & ~StallD;
  assign PCSrcD[1] = JumpD & ValidD & ~StallD;

  assign PCBranchD = PCPlus4D + {SignImmD[XLEN-3:0], 2'b00};
  assign PCjump    = {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00};

`ifdef DEC_STAT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && ValidD && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1))           FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

  logic        CLK;
  logic        rst;
  logic [31:0] RD;
  logic [31:0] PCPlus4F;
  logic        StallD;
  logic [1:0]  ForwardAD;
  logic [1:0]  ForwardBD;
  logic [31:0] ALUOutM;
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] RD1, RD2, SignImmD, PCBranchD, PCjump;
  logic [1:0]  PCSrcD;
  logic [4:0]  RsD, RtD, RdD;
  logic [2:0]  ALUControlD;
  logic        MemWriteD, RegWriteD, RegDstD, ALUSrcD, MemtoRegD, JumpD, BranchD, ValidD;
`ifdef DEC_STAT_EN
  logic [15:0] StallCnt, FlushCnt;
  logic [31:0] bRD1, bRD2, bSignImmD, bPCBranchD, bPCjump;
  logic [1:0]  bPCSrcD;
  logic [4:0]  bRsD, bRtD, bRdD;
  logic [2:0]  bALUControlD;
  logic        bMemWriteD, bRegWriteD, bRegDstD, bALUSrcD, bMemtoRegD, bJumpD, bBranchD, bValidD;
  logic [1:0]  bStallCnt, bFlushCnt;
`endif

  int n_checks;
  int n_bad;

  decode_stage_p #(.XLEN(32), .NREG(32), .AW(5), .CNT_W(16)) u_dut (
    .CLK(CLK), .rst(rst), .RD(RD), .PCPlus4F(PCPlus4F), .StallD(StallD),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .RD1(RD1), .RD2(RD2),
    .SignImmD(SignImmD), .PCBranchD(PCBranchD), .PCjump(PCjump), .PCSrcD(PCSrcD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD), .MemWriteD(MemWriteD),
    .RegWriteD(RegWriteD), .RegDstD(RegDstD), .ALUSrcD(ALUSrcD), .MemtoRegD(MemtoRegD),
    .JumpD(JumpD), .BranchD(BranchD), .ValidD(ValidD)
`ifdef DEC_STAT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

`ifdef DEC_STAT_EN
  // Narrow-counter instance for the saturation check.
  decode_stage_p #(.XLEN(32), .NREG(32), .AW(5), .CNT_W(2)) u_dut_sat (
    .CLK(CLK), .rst(rst), .RD(RD), .PCPlus4F(PCPlus4F), .StallD(StallD),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .RD1(bRD1), .RD2(bRD2),
    .SignImmD(bSignImmD), .PCBranchD(bPCBranchD), .PCjump(bPCjump), .PCSrcD(bPCSrcD),
    .RsD(bRsD), .RtD(bRtD), .RdD(bRdD), .ALUControlD(bALUControlD), .MemWriteD(bMemWriteD),
    .RegWriteD(bRegWriteD), .RegDstD(bRegDstD), .ALUSrcD(bALUSrcD), .MemtoRegD(bMemtoRegD),
    .JumpD(bJumpD), .BranchD(bBranchD), .ValidD(bValidD),
    .StallCnt(bStallCnt), .FlushCnt(bFlushCnt)
  );
`endif

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before anyone looks.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Packed control word {ALUControl, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg, Jump, Branch}.
  function automatic logic [31:0] ctl(input logic [2:0] alu, input logic mw, input logic rw,
                                      input logic rdst, input logic asrc, input logic m2r,
                                      input logic j, input logic b);
    return {22'd0, alu, mw, rw, rdst, asrc, m2r, j, b};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {22'd0, ALUControlD, MemWriteD, RegWriteD, RegDstD, ALUSrcD, MemtoRegD, JumpD, BranchD};
  endfunction

  task automatic decode_case(input string tag, input logic [31:0] instr,
                             input logic [31:0] exp_ctl, input logic [31:0] exp_imm);
    RD = instr;
    step();
    check_val({tag, "_ctl"}, ctl_obs(), exp_ctl);
    check_val({tag, "_imm"}, SignImmD, exp_imm);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_bad     = 0;
    rst       = 1'b0;
    RD        = 32'h2008_0005;   // addi $8,$0,5
    PCPlus4F  = 32'h4;
    StallD    = 1'b0;
    ForwardAD = 2'b00;
    ForwardBD = 2'b00;
    ALUOutM   = '0;
    ResultW   = '0;
    RegWriteW = 1'b0;
    WriteRegW = '0;

    // 1. reset
    step();
    step();
    check_val("rst_valid", {31'd0, ValidD}, 32'd0);
    check_val("rst_ctl", ctl_obs(), ctl(3'b010, 0, 0, 0, 0, 0, 0, 0));
    check_val("rst_rd1", RD1, 32'd0);
    check_val("rst_rd2", RD2, 32'd0);
    check_val("rst_pcsrc", {30'd0, PCSrcD}, 32'd0);
    rst = 1'b1;
    step();
    check_val("addi_valid", {31'd0, ValidD}, 32'd1);
    check_val("addi_ctl", ctl_obs(), ctl(3'b010, 0, 1, 0, 1, 0, 0, 0));
    check_val("addi_imm", SignImmD, 32'd5);
    check_val("addi_rt", {27'd0, RtD}, 32'd8);

    // 2. bypass: add $9,$8,$0 while writing reg 8
    RD = 32'h0100_4820;
    step();
    RegWriteW = 1'b1;
    WriteRegW = 5'd8;
    ResultW   = 32'h1234;
    #1;
    check_val("byp_rd1", RD1, 32'h1234);
    check_val("byp_rd2", RD2, 32'd0);
    check_val("add_ctl", ctl_obs(), ctl(3'b010, 0, 1, 1, 0, 0, 0, 0));
    check_val("add_rd", {27'd0, RdD}, 32'd9);
    // add $9,$0,$8 while a write to reg 0 is presented; edge commits reg 8
    RD = 32'h0008_4820;
    step();
    WriteRegW = 5'd0;
    ResultW   = 32'h5555;
    #1;
    check_val("r0_byp_rd1", RD1, 32'd0);
    check_val("reg8_rd2", RD2, 32'h1234);

    // 3. beq $8,$9,+3 with forwarded A and bypassed B
    RD        = 32'h1109_0003;
    PCPlus4F  = 32'h100;
    step();                         // write to reg 0 at this edge must be ignored
    WriteRegW = 5'd9;
    ResultW   = 32'd7;
    ForwardAD = 2'b01;
    ALUOutM   = 32'd7;
    #1;
    check_val("beq_rd1", RD1, 32'h1234);
    check_val("beq_rd2", RD2, 32'd7);
    check_val("beq_ctl", ctl_obs(), ctl(3'b110, 0, 0, 0, 0, 0, 0, 1));
    check_val("beq_pcsrc", {30'd0, PCSrcD}, 32'd1);
    check_val("beq_target", PCBranchD, 32'h10C);
    RD = 32'h2008_0005;
    step();                         // commits reg 9 = 7 and flushes
    RegWriteW = 1'b0;
    ForwardAD = 2'b00;
    #1;
    check_val("flush_valid", {31'd0, ValidD}, 32'd0);
    check_val("flush_ctl", ctl_obs(), ctl(3'b010, 0, 0, 0, 0, 0, 0, 0));
    check_val("flush_rs", {27'd0, RsD}, 32'd0);

    // 4. bne $8,$9 (0x1234 vs 7) under stall
    RD       = 32'h1509_0001;
    PCPlus4F = 32'h200;
    step();
    check_val("bne_pcsrc", {30'd0, PCSrcD}, 32'd1);
    StallD = 1'b1;
    #1;
    check_val("stall_pcsrc", {30'd0, PCSrcD}, 32'd0);
    RD       = 32'h2008_0005;
    PCPlus4F = 32'h999;
    step();
    check_val("stall_valid", {31'd0, ValidD}, 32'd1);
    check_val("stall_rs", {27'd0, RsD}, 32'd8);
    check_val("stall_ctl", ctl_obs(), ctl(3'b110, 0, 0, 0, 0, 0, 0, 1));
    check_val("stall_target", PCBranchD, 32'h204);
    check_val("stall_pcsrc2", {30'd0, PCSrcD}, 32'd0);
    StallD = 1'b0;
    #1;
    check_val("unstall_pcsrc", {30'd0, PCSrcD}, 32'd1);
    step();
    check_val("bne_flush_valid", {31'd0, ValidD}, 32'd0);

    // 5. blez with A = -1 (forwarded from ResultW), negative offset
    ForwardAD = 2'b10;
    ResultW   = 32'hFFFF_FFFF;
    RD        = 32'h1900_FFFE;
    PCPlus4F  = 32'h300;
    step();
    check_val("blez_imm", SignImmD, 32'hFFFF_FFFE);
    check_val("blez_pcsrc", {30'd0, PCSrcD}, 32'd1);
    check_val("blez_target", PCBranchD, 32'h2F8);
    step();                         // flush
    ForwardAD = 2'b00;
    RD        = 32'h1C00_0005;      // bgtz $0
    PCPlus4F  = 32'h400;
    step();
    check_val("bgtz0_pcsrc", {30'd0, PCSrcD}, 32'd0);
    check_val("bgtz_ctl", ctl_obs(), ctl(3'b110, 0, 0, 0, 0, 0, 0, 1));
    ForwardAD = 2'b01;
    ALUOutM   = 32'd1;
    #1;
    check_val("bgtz1_pcsrc", {30'd0, PCSrcD}, 32'd1);
    ALUOutM = 32'h8000_0000;
    #1;
    check_val("bgtzneg_pcsrc", {30'd0, PCSrcD}, 32'd0);
    ForwardAD = 2'b00;

    // jump
    RD       = 32'h0800_0040;
    PCPlus4F = 32'h1000_0004;
    step();
    check_val("j_target", PCjump, 32'h1000_0100);
    check_val("j_pcsrc", {30'd0, PCSrcD}, 32'd2);
    check_val("j_ctl", ctl_obs(), ctl(3'b010, 0, 0, 0, 0, 0, 1, 0));
    RD = 32'h0000_0000;
    step();
    check_val("j_flush_valid", {31'd0, ValidD}, 32'd0);

    // decode table
    decode_case("andi", 32'h3108_FFFF, ctl(3'b000, 0, 1, 0, 1, 0, 0, 0), 32'h0000_FFFF);
    decode_case("ori",  32'h3508_FFFF, ctl(3'b001, 0, 1, 0, 1, 0, 0, 0), 32'h0000_FFFF);
    decode_case("addi", 32'h2108_FFFF, ctl(3'b010, 0, 1, 0, 1, 0, 0, 0), 32'hFFFF_FFFF);
    decode_case("sub",  32'h0100_4822, ctl(3'b110, 0, 1, 1, 0, 0, 0, 0), 32'h0000_4822);
    decode_case("and",  32'h0100_4824, ctl(3'b000, 0, 1, 1, 0, 0, 0, 0), 32'h0000_4824);
    decode_case("or",   32'h0100_4825, ctl(3'b001, 0, 1, 1, 0, 0, 0, 0), 32'h0000_4825);
    decode_case("slt",  32'h0100_482A, ctl(3'b111, 0, 1, 1, 0, 0, 0, 0), 32'h0000_482A);
    decode_case("lw",   32'h8D09_0004, ctl(3'b010, 0, 1, 0, 1, 1, 0, 0), 32'h0000_0004);
    decode_case("sw",   32'hAD09_0004, ctl(3'b010, 1, 0, 0, 1, 0, 0, 0), 32'h0000_0004);
    decode_case("badop", 32'hFC00_0000, ctl(3'b010, 0, 0, 0, 0, 0, 0, 0), 32'h0000_0000);
    decode_case("badfn", 32'h0100_4821, ctl(3'b010, 0, 0, 0, 0, 0, 0, 0), 32'h0000_4821);

    // 7. reset mid-stream clears registers and the in-flight instruction
    RD  = 32'h0100_4820;            // add $9,$8,$0
    rst = 1'b0;
    step();
    check_val("rst2_valid", {31'd0, ValidD}, 32'd0);
    rst = 1'b1;
    step();
    check_val("rst2_valid1", {31'd0, ValidD}, 32'd1);
    check_val("rst2_rd1", RD1, 32'd0);

`ifdef DEC_STAT_EN
    // 6. performance counters
    rst = 1'b0;
    RD  = 32'h2008_0005;
    step();
    rst = 1'b1;
    step();
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) step();
    StallD = 1'b0;
    RD     = 32'h1000_0001;         // beq $0,$0 : always taken
    step();
    RD = 32'h2008_0005;
    step();
    check_val("stall_cnt3", {16'd0, StallCnt}, 32'd3);
    check_val("flush_cnt1", {16'd0, FlushCnt}, 32'd1);
    step();                         // reload a valid addi after the bubble
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) step();
    StallD = 1'b0;
    check_val("stall_cnt5", {16'd0, StallCnt}, 32'd5);
    check_val("stall_sat", {30'd0, bStallCnt}, 32'd3);
    check_val("flush_sat1", {30'd0, bFlushCnt}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised next-generation decode stage for the 5-stage MIPS pipeline. It holds the IF/ID pipeline register with a valid bit, stall and flush, and an internal register file with write-through bypass. It decodes control, resolves branches early with 3-way forwarding and four branch conditions (BEQ/BNE/BLEZ/BGTZ), and computes branch/jump targets. It sits between the fetch stage and the ID/EX register; the hazard unit drives StallD, ForwardAD and ForwardBD.

Parameters:
XLEN, 32, datapath/PC width; must be >= 32 (instruction word is always 32 bits).
NREG, 32, number of architectural registers; must be a power of 2 and <= 32.
AW, 5, register address width; must equal log2(NREG).
CNT_W, 16, width of the performance counters (used only with DEC_STAT_EN).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
RD  in  32  instruction from instruction memory (fetch stage).
PCPlus4F  in  XLEN  fetch PC+4.
StallD  in  1  1 = hold the IF/ID register.
ForwardAD, ForwardBD  in  2  each: 00 = register file, 01 = ALUOutM, 10 = ResultW, 11 = register file.
ALUOutM, ResultW  in  XLEN  forwarded values.
RegWriteW  in  1  writeback enable.
WriteRegW  in  AW  writeback address.
RD1, RD2  out  XLEN  register file read data (includes bypass, excludes the forward mux).
SignImmD  out  XLEN  extended immediate.
PCBranchD, PCjump  out  XLEN  branch and jump targets.
PCSrcD  out  2  {jump taken, branch taken}.
RsD, RtD, RdD  out  AW  InstrD[25:21], [20:16], [15:11], each truncated to AW bits.
ALUControlD  out  3  ALU operation.
MemWriteD, RegWriteD, RegDstD, ALUSrcD, MemtoRegD, JumpD, BranchD  out  1  control signals.
ValidD  out  1  the IF/ID register holds a real instruction.
StallCnt, FlushCnt  out  CNT_W  only present when DEC_STAT_EN is defined.

Behaviour:
- Reset, when rst==0 at a rising edge:
  - InstrD=0, PCPlus4D=0, ValidD=0; all registers are cleared to 0.
  - Reset has priority over stall, flush and write. A reset mid-stream discards the in-flight instruction.
- IF/ID register, evaluated at each edge in priority order:
  - Reset.
  - StallD=1: hold all contents.
  - FlushD=1: load InstrD=0, PCPlus4D=0, ValidD=0 (bubble).
  - Otherwise: load InstrD=RD, PCPlus4D=PCPlus4F, ValidD=1.
  - Latency from fetch to decode outputs is 1 cycle.
- FlushD = (PCSrcD != 00) & ~StallD, computed internally.
- PCSrcD is forced to 00 while StallD=1, because forwarded operands may be stale during a stall.
- Register file:
  - Write at the rising edge when RegWriteW=1 and WriteRegW != 0.
  - Register 0 always reads 0.
  - Same-cycle bypass: if RegWriteW=1, WriteRegW == the read address, and that address != 0, then RD1/RD2 return ResultW.
- Branch operands: A/B = the forward mux over RD1/RD2.
  - BEQ: A==B.
  - BNE: A!=B.
  - BLEZ: A is signed <= 0.
  - BGTZ: A is signed > 0.
  - PCSrcD[0] = BranchD & cond & ValidD & ~StallD.
  - PCSrcD[1] = JumpD & ValidD & ~StallD.
- Targets:
  - PCBranchD = PCPlus4D + (SignImmD<<2), modulo 2^XLEN (wrap ignored).
  - PCjump = {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00}.
- Immediate: zero-extended for ANDI/ORI; sign-extended to XLEN otherwise.
- Decode (opcode / funct):
  - R-type 000000, funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - lw 100011, sw 101011, addi 001000, andi 001100, ori 001101.
  - beq 000100, bne 000101, blez 000110, bgtz 000111, j 000010.
  - ALUControlD: add 010, sub 110, and 000, or 001, slt 111.
  - Branches use ALUControlD = sub (110).
- Output gating: when ValidD=0, or the opcode/funct is unknown, all 1-bit controls are 0 and ALUControlD=010. A bubble is therefore architecturally a NOP.

Optional Feature:
DEC_STAT_EN
- Defined:
  - StallCnt increments on every edge with StallD=1 and ValidD=1.
  - FlushCnt increments on every edge with FlushD=1.
  - Both counters saturate at 2^CNT_W-1 and reset to 0.
- Undefined: the counters and their ports are absent; nothing else changes.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with RD=0x20080005 -> ValidD=0, all controls 0, RD1=RD2=0. After rst=1, one edge -> ValidD=1, RegWriteD=1, ALUSrcD=1, SignImmD=5.
2. Bypass: RegWriteW=1, WriteRegW=8, ResultW=0x1234, decode `add $9,$8,$0` -> RD1=0x1234 in the same cycle. The same write to reg 0 -> RD1 reads 0.
3. Branch and forward: beq $8,$9,+3, ForwardAD=01, ALUOutM=7, RD2=7, PCPlus4D=0x100 -> PCSrcD=01, PCBranchD=0x10C. Next edge -> ValidD=0 (bubble).
4. Stall priority: bne with unequal operands and StallD=1 -> PCSrcD=00, InstrD held.
5. Sign and jump:
   - BLEZ with A=0xFFFFFFFF -> taken.
   - BGTZ with A=0 -> not taken.
   - j 0x0000040 at PCPlus4D=0x10000004 -> PCjump=0x10000100, PCSrcD=10.
6. DEC_STAT_EN: 3 stall cycles with a valid instruction, then 1 taken branch -> StallCnt=3, FlushCnt=1. With CNT_W=2 and 5 stalls -> StallCnt=3 (saturated).
